// File: rtl/multicycle_controller_pkg.sv
//============================================================================
// Module      : mc_pkg
// Description : Shared types and encodings for the multicycle CPU controller.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_MRD = 4'd2,
    S_MWB = 4'd3,
    S_MWR = 4'd4,
    S_JMP = 4'd5,
    S_BRZ = 4'd6,
    S_EXC = 4'd7,
    S_WBC = 4'd8,
    S_EXI = 4'd9,
    S_WBI = 4'd10
  } state_t;

  localparam logic [2:0] C_OP_LOAD  = 3'b000;
  localparam logic [2:0] C_OP_STORE = 3'b001;
  localparam logic [2:0] C_OP_JUMP  = 3'b010;
  localparam logic [2:0] C_OP_BRZ   = 3'b011;
  localparam logic [2:0] C_OP_TYPEC = 3'b100;
  localparam logic [2:0] C_OP_ADDI  = 3'b101;
  localparam logic [2:0] C_OP_SUBI  = 3'b110;
  localparam logic [2:0] C_OP_ANDI  = 3'b111;

  localparam logic [1:0] C_SRCB_RI  = 2'b00;
  localparam logic [1:0] C_SRCB_ONE = 2'b01;
  localparam logic [1:0] C_SRCB_IMM = 2'b10;

  localparam logic [2:0] C_ALU_ADD   = 3'b000;
  localparam logic [2:0] C_ALU_SUB   = 3'b001;
  localparam logic [2:0] C_ALU_AND   = 3'b010;
  localparam logic [2:0] C_ALU_TYPEC = 3'b111;

  // Bundle of every datapath strobe and mux select driven by the controller.
  typedef struct packed {
    logic       pcWrite;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       iOrD;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic       pcSrc;
  } ctl_t;

  function automatic logic [2:0] imm_alu_op(input logic [2:0] opc);
    case (opc)
      C_OP_SUBI: imm_alu_op = C_ALU_SUB;
      C_OP_ANDI: imm_alu_op = C_ALU_AND;
      default:   imm_alu_op = C_ALU_ADD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_if.sv
//============================================================================
// Module      : multicycle_controller_if
// Description : Controller <-> datapath bus: status flags in, strobes out.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface multicycle_controller_if #(
  parameter int OPC_W = 3
);
  logic [OPC_W-1:0] opcode;
  logic             zero;
  logic             noOp;
  logic             moveTo;
  logic             memReady;

  logic             pcWrite;
  logic             irWrite;
  logic             memRead;
  logic             memWrite;
  logic             iOrD;
  logic             regWrite;
  logic             regDst;
  logic             memToReg;
  logic             aluSrcA;
  logic [1:0]       aluSrcB;
  logic [2:0]       aluOp;
  logic             pcSrc;

  modport master (
    input  opcode, zero, noOp, moveTo, memReady,
    output pcWrite, irWrite, memRead, memWrite, iOrD, regWrite, regDst,
           memToReg, aluSrcA, aluSrcB, aluOp, pcSrc
  );

  modport slave (
    output opcode, zero, noOp, moveTo, memReady,
    input  pcWrite, irWrite, memRead, memWrite, iOrD, regWrite, regDst,
           memToReg, aluSrcA, aluSrcB, aluOp, pcSrc
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_controller.sv
//============================================================================
// Module      : multicycle_controller
// Description : Main sequencing FSM of the multicycle CPU. Optional macro
//               MC_CTRL_PERF_EN adds the retired-instruction counter.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module multicycle_controller
  import mc_pkg::*;
#(
  parameter int OPC_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [15:0]            retired
`endif
);

  state_t           r_state;
  ctl_t             w_ctl;
  logic [OPC_W-1:0] w_opc;

  assign w_opc = bus.opcode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IF;
    end else begin
      case (r_state)
        S_IF:  if (bus.memReady) r_state <= S_ID;
        S_ID: begin
          case (w_opc)
            C_OP_LOAD:                      r_state <= S_MRD;
            C_OP_STORE:                     r_state <= S_MWR;
            C_OP_JUMP:                      r_state <= S_JMP;
            C_OP_BRZ:                       r_state <= S_BRZ;
            C_OP_TYPEC:                     r_state <= S_EXC;
            C_OP_ADDI, C_OP_SUBI, C_OP_ANDI: r_state <= S_EXI;
            default:                        r_state <= S_IF;
          endcase
        end
        S_MRD: if (bus.memReady) r_state <= S_MWB;
        S_MWB: r_state <= S_IF;
        S_MWR: if (bus.memReady) r_state <= S_IF;
        S_JMP: r_state <= S_IF;
        S_BRZ: r_state <= S_IF;
        S_EXC: r_state <= bus.noOp ? S_IF : S_WBC;
        S_WBC: r_state <= S_IF;
        S_EXI: r_state <= S_WBI;
        S_WBI: r_state <= S_IF;
        default: r_state <= S_IF;
      endcase
    end
  end

  // Strobes are decoded from the state; the few input-qualified ones (fetch
  // loads, branch, move target) follow their flags within the same cycle.
  always_comb begin
    w_ctl = '0;
    case (r_state)
      S_IF: begin
        w_ctl.memRead = 1'b1;
        w_ctl.aluSrcB = C_SRCB_ONE;
        w_ctl.aluOp   = C_ALU_ADD;
        w_ctl.irWrite = bus.memReady;
        w_ctl.pcWrite = bus.memReady;
      end
      S_MRD: begin
        w_ctl.memRead = 1'b1;
        w_ctl.iOrD    = 1'b1;
      end
      S_MWB: begin
        w_ctl.regWrite = 1'b1;
        w_ctl.memToReg = 1'b1;
      end
      S_MWR: begin
        w_ctl.memWrite = 1'b1;
        w_ctl.iOrD     = 1'b1;
      end
      S_JMP: begin
        w_ctl.pcWrite = 1'b1;
        w_ctl.pcSrc   = 1'b1;
      end
      S_BRZ: begin
        w_ctl.pcWrite = bus.zero;
        w_ctl.pcSrc   = 1'b1;
      end
      S_EXC: begin
        w_ctl.aluOp   = C_ALU_TYPEC;
        w_ctl.aluSrcA = 1'b1;
        w_ctl.aluSrcB = C_SRCB_RI;
      end
      S_WBC: begin
        w_ctl.aluOp    = C_ALU_TYPEC;
        w_ctl.aluSrcA  = 1'b1;
        w_ctl.aluSrcB  = C_SRCB_RI;
        w_ctl.regWrite = 1'b1;
        w_ctl.regDst   = bus.moveTo;
      end
      S_EXI: begin
        w_ctl.aluSrcA = 1'b1;
        w_ctl.aluSrcB = C_SRCB_IMM;
        w_ctl.aluOp   = imm_alu_op(w_opc);
      end
      S_WBI: begin
        w_ctl.aluSrcA  = 1'b1;
        w_ctl.aluSrcB  = C_SRCB_IMM;
        w_ctl.aluOp    = imm_alu_op(w_opc);
        w_ctl.regWrite = 1'b1;
      end
      default: ;
    endcase
    if (rst) w_ctl = '0;
  end

  assign bus.pcWrite  = w_ctl.pcWrite;
  assign bus.irWrite  = w_ctl.irWrite;
  assign bus.memRead  = w_ctl.memRead;
  assign bus.memWrite = w_ctl.memWrite;
  assign bus.iOrD     = w_ctl.iOrD;
  assign bus.regWrite = w_ctl.regWrite;
  assign bus.regDst   = w_ctl.regDst;
  assign bus.memToReg = w_ctl.memToReg;
  assign bus.aluSrcA  = w_ctl.aluSrcA;
  assign bus.aluSrcB  = w_ctl.aluSrcB;
  assign bus.aluOp    = w_ctl.aluOp;
  assign bus.pcSrc    = w_ctl.pcSrc;

`ifdef MC_CTRL_PERF_EN
  logic        w_retire;
  logic [15:0] r_retired;

  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_MWB, S_JMP, S_BRZ, S_WBC, S_WBI: w_retire = 1'b1;
      S_MWR:                             w_retire = bus.memReady;
      S_EXC:                             w_retire = bus.noOp;
      default:                           w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + 16'd1;
    end
  end

  assign retired = r_retired;
`endif

endmodule

`default_nettype wire
